// File: rtl/btn_pkg.sv
// Shared state encoding and default 100 MHz timing for the button conditioner.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_t;

  localparam int unsigned DEF_NUM_BTN         = 32'd3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
  localparam int unsigned DEF_HOLD_CYCLES     = 32'd100000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 32'd25000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM, long-press and auto-repeat counters.
import btn_pkg::*;

module btn_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned BTN_ACTIVE_LOW  = 32'd0,
  parameter int unsigned CNT_W           = 32'd8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REP_TERM  =
    CNT_W'((REPEAT_CYCLES == 32'd0) ? 32'd0 : (REPEAT_CYCLES - 32'd1));
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(32'd1);
  localparam logic             REPEAT_EN = (REPEAT_CYCLES != 32'd0);
  localparam logic             INV       = 1'(BTN_ACTIVE_LOW);

  logic             s1_r, s2_r;
  btn_state_t       state_r;
  logic [CNT_W-1:0] cnt_r, hold_cnt_r, rep_cnt_r;
  logic             held_flag_r;
  logic             level_r, press_r, release_r, hold_r, repeat_r;

  // Two-stage synchronizer with optional polarity inversion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= btn_raw ^ INV;
      s2_r <= s1_r;
    end
  end

  // Debounce / hold / repeat FSM with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      hold_cnt_r  <= '0;
      rep_cnt_r   <= '0;
      held_flag_r <= 1'b0;
      level_r     <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      hold_r      <= 1'b0;
      repeat_r    <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      hold_r    <= 1'b0;
      repeat_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (s2_r) begin
            state_r <= DB_PRESS;
            cnt_r   <= '0;
          end
        end
        DB_PRESS: begin
          if (!s2_r) begin
            state_r <= IDLE;
          end else if (cnt_r == DB_TERM) begin
            state_r     <= PRESSED;
            press_r     <= 1'b1;
            level_r     <= 1'b1;
            hold_cnt_r  <= '0;
            held_flag_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end
        PRESSED: begin
          if (!s2_r) begin
            state_r <= DB_RELEASE;
            cnt_r   <= '0;
          end else if (hold_cnt_r == HOLD_TERM) begin
            state_r     <= HELD;
            hold_r      <= 1'b1;
            held_flag_r <= 1'b1;
            rep_cnt_r   <= '0;
          end else begin
            hold_cnt_r <= hold_cnt_r + ONE;
          end
        end
        HELD: begin
          if (!s2_r) begin
            state_r <= DB_RELEASE;
            cnt_r   <= '0;
          end else if (REPEAT_EN) begin
            if (rep_cnt_r == REP_TERM) begin
              repeat_r  <= 1'b1;
              rep_cnt_r <= '0;
            end else begin
              rep_cnt_r <= rep_cnt_r + ONE;
            end
          end
        end
        DB_RELEASE: begin
          // The return edge counts as a pressed cycle, so a bounce costs only the low cycles
          if (s2_r) begin
            if (held_flag_r) begin
              state_r <= HELD;
              if (REPEAT_EN && (rep_cnt_r != REP_TERM)) rep_cnt_r <= rep_cnt_r + ONE;
            end else begin
              state_r <= PRESSED;
              if (hold_cnt_r != HOLD_TERM) hold_cnt_r <= hold_cnt_r + ONE;
            end
          end else if (cnt_r == DB_TERM) begin
            state_r   <= IDLE;
            release_r <= 1'b1;
            level_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign hold_pulse    = hold_r;
  assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw push-buttons into debounced levels and one-cycle event strobes.
import btn_pkg::*;

module button_conditioner #(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned BTN_ACTIVE_LOW  = 32'd0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] hold_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  localparam int unsigned CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 32'd1;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clock         (clock),
      .reset_n       (reset_n),
      .btn_raw       (btn_raw[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .hold_pulse    (hold_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule
